// File: rtl/sinstr_fetch.sv
// Instruction fetch front end: credit-limited in-order requests, PC side queue,
// output FIFO, and redirect handling that drops responses still in flight.
module sinstr_fetch #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_o,
  output logic [DATA_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_gnt_i,
  input  logic                  imem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  input  logic                  redirect_i,
  input  logic [DATA_WIDTH-1:0] redirect_pc_i,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [DATA_WIDTH-1:0] instr_pc_o
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [DATA_WIDTH-1:0] r_pc;
  logic [CW-1:0]         r_out;   // all granted, unanswered requests (incl. ones to drop)
  logic [CW-1:0]         r_disc;
  logic [CW-1:0]         r_cnt;
  logic [PW-1:0]         r_rptr, r_wptr, r_qrptr, r_qwptr;
  logic [DATA_WIDTH-1:0] r_fi  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] r_fpc [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] r_pcq [FIFO_DEPTH];

  logic w_credit, w_acc, w_drop, w_keep, w_push, w_pop;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_credit    = ({1'b0, r_out} + {1'b0, r_cnt}) < (CW+1)'(FIFO_DEPTH);
  assign imem_req_o  = w_credit && !redirect_i && !rst;
  assign imem_addr_o = {r_pc[DATA_WIDTH-1:2], 2'b00};
  assign w_acc       = imem_req_o && imem_gnt_i;
  assign w_drop      = imem_rvalid_i && (r_disc != '0);
  assign w_keep      = imem_rvalid_i && (r_disc == '0);
  assign w_push      = w_keep && !redirect_i;
  assign w_pop       = instr_valid_o && instr_ready_i && !redirect_i;

  assign instr_valid_o = (r_cnt != '0);
  assign instr_o       = instr_valid_o ? r_fi[r_rptr]  : '0;
  assign instr_pc_o    = instr_valid_o ? r_fpc[r_rptr] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc    <= RESET_PC;
      r_out   <= '0;
      r_disc  <= '0;
      r_cnt   <= '0;
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_qrptr <= '0;
      r_qwptr <= '0;
    end else begin
      r_out <= r_out + CW'(w_acc) - CW'(imem_rvalid_i);
      if (redirect_i) begin
        // every request still in flight after this edge belongs to the old path
        r_pc    <= {redirect_pc_i[DATA_WIDTH-1:2], 2'b00};
        r_disc  <= r_out - CW'(imem_rvalid_i);
        r_cnt   <= '0;
        r_rptr  <= '0;
        r_wptr  <= '0;
        r_qrptr <= '0;
        r_qwptr <= '0;
      end else begin
        if (w_acc) begin
          r_pc    <= r_pc + DATA_WIDTH'(4);
          r_qwptr <= f_inc(r_qwptr);
        end
        if (w_drop) r_disc  <= r_disc - CW'(1);
        if (w_keep) r_qrptr <= f_inc(r_qrptr);
        if (w_push) r_wptr  <= f_inc(r_wptr);
        if (w_pop)  r_rptr  <= f_inc(r_rptr);
        r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_acc) r_pcq[r_qwptr] <= imem_addr_o;
    if (w_push) begin
      r_fi[r_wptr]  <= imem_rdata_i;
      r_fpc[r_wptr] <= r_pcq[r_qrptr];
    end
  end
endmodule

// File: tb/tb_sinstr_fetch.sv
// Bench for sinstr_fetch: directed scenarios plus random traffic against a
// program-order model (epoch-tagged memory queue, expected PC stream).
module tb_sinstr_fetch;
  localparam int          DW    = 32;
  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0;

  logic          clk = 1'b0;
  logic          rst;
  logic          imem_req_o, imem_gnt_i, imem_rvalid_i;
  logic [DW-1:0] imem_addr_o, imem_rdata_i, redirect_pc_i;
  logic          redirect_i, instr_valid_o, instr_ready_i;
  logic [DW-1:0] instr_o, instr_pc_o;

  sinstr_fetch #(.DATA_WIDTH(DW), .RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .instr_o(instr_o), .instr_pc_o(instr_pc_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int epoch; int due; } rsp_t;
  rsp_t        mq[$];
  int          epoch, buffered, cyc, n_chk, n_err;
  logic [31:0] fpc, epc;
  logic        ob_req, ob_valid, ob_acc;
  logic [31:0] ob_addr, ob_pc, ob_instr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0000_0013;
      32'h4:   return 32'h0010_0093;
      32'h8:   return 32'h0020_0113;
      32'h10:  return 32'h0031_2233;
      default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
    endcase
  endfunction

  task automatic model_reset();
    mq.delete();
    buffered = 0;
    epoch++;
    fpc = RPC;
    epc = RPC;
  endtask

  task automatic drive_idle();
    imem_gnt_i = 0; imem_rvalid_i = 0; imem_rdata_i = '0;
    redirect_i = 0; redirect_pc_i = '0; instr_ready_i = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  // one clock cycle: drive, check against the model, advance the model
  task automatic step(input bit g, input bit r, input bit rd, input logic [31:0] rpc, input int lat);
    bit   rv, exp_req, pop;
    rsp_t h;
    @(posedge clk); #1;
    cyc++;
    rv = (mq.size() > 0) && (mq[0].due <= cyc);
    imem_rvalid_i = rv;
    imem_rdata_i  = rv ? word(mq[0].addr) : $urandom;
    imem_gnt_i = g; instr_ready_i = r; redirect_i = rd; redirect_pc_i = rpc;
    #1;
    exp_req = ((mq.size() + buffered) < DEPTH) && !rd;
    chk("req", {31'd0, imem_req_o}, {31'd0, exp_req});
    chk("valid", {31'd0, instr_valid_o}, {31'd0, buffered != 0});
    chk("addr", imem_addr_o, fpc);
    if (buffered != 0) begin
      chk("instr_pc", instr_pc_o, epc);
      chk("instr", instr_o, word(epc));
    end
    ob_req = imem_req_o; ob_valid = instr_valid_o; ob_addr = imem_addr_o;
    ob_pc = instr_pc_o; ob_instr = instr_o; ob_acc = exp_req && g;
    pop = (buffered != 0) && r && !rd;
    if (rv) begin
      h = mq.pop_front();
      if (h.epoch == epoch && !rd) buffered++;
    end
    if (pop) begin buffered--; epc += 4; end
    if (ob_acc) begin mq.push_back('{fpc, epoch, cyc + lat}); fpc += 4; end
    if (rd) begin
      epoch++; buffered = 0;
      fpc = {rpc[31:2], 2'b00}; epc = fpc;
    end
  endtask

  initial begin
    int          gc, vc, nseen;
    bit          found;
    logic [31:0] spc[3], sins[3];
    n_chk = 0; n_err = 0; cyc = 0; epoch = 0;
    rst = 1'b1;
    drive_idle();
    #3;
    chk("rst_req", {31'd0, imem_req_o}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("rst_instr", instr_o, 32'd0);
    chk("rst_instr_pc", instr_pc_o, 32'd0);
    chk("rst_addr", imem_addr_o, RPC);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();

    // straight-line fetch, 1-cycle memory
    gc = -1; vc = -1; nseen = 0;
    for (int i = 0; i < 8; i++) begin
      step(1, 1, 0, 0, 1);
      if (i == 0) chk("first_req", {31'd0, ob_req}, 32'd1);
      if (ob_acc && gc < 0) gc = cyc;
      if (ob_valid && vc < 0) vc = cyc;
      if (ob_valid && nseen < 3) begin spc[nseen] = ob_pc; sins[nseen] = ob_instr; nseen++; end
    end
    chk("first_valid_lat", vc - gc, 32'd2);
    chk("seq_pc0", spc[0], 32'h0);  chk("seq_in0", sins[0], 32'h0000_0013);
    chk("seq_pc1", spc[1], 32'h4);  chk("seq_in1", sins[1], 32'h0010_0093);
    chk("seq_pc2", spc[2], 32'h8);  chk("seq_in2", sins[2], 32'h0020_0113);

    // decode stalled: buffer fills, requests stop, resume at 0x8
    do_reset();
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 1);
    chk("stall_req", {31'd0, ob_req}, 32'd0);
    chk("stall_pc", ob_pc, 32'h0);
    chk("stall_valid", {31'd0, ob_valid}, 32'd1);
    found = 0;
    for (int i = 0; i < 6 && !found; i++) begin
      step(1, 1, 0, 0, 1);
      if (ob_acc) begin found = 1; chk("resume_addr", ob_addr, 32'h8); end
    end
    chk("resume_seen", {31'd0, found}, 32'd1);

    // redirect with two responses outstanding
    do_reset();
    step(1, 1, 0, 0, 5);
    step(1, 1, 0, 0, 5);
    step(1, 1, 1, 32'h10, 1);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1, 1, 0, 0, 1);
      if (ob_valid) begin
        found = 1;
        chk("redir_pc", ob_pc, 32'h10);
        chk("redir_instr", ob_instr, 32'h0031_2233);
      end
    end
    chk("redir_seen", {31'd0, found}, 32'd1);

    // unaligned redirect target
    step(0, 1, 1, 32'h13, 1);
    step(0, 1, 0, 0, 1);
    chk("align_addr", ob_addr, 32'h10);
    repeat (8) step(0, 1, 0, 0, 1);

    // PC wrap at the top of the address space
    step(0, 1, 1, 32'hFFFF_FFFC, 1);
    step(1, 1, 0, 0, 1);
    chk("wrap_top", ob_addr, 32'hFFFF_FFFC);
    chk("wrap_req", {31'd0, ob_req}, 32'd1);
    step(0, 1, 0, 0, 1);
    chk("wrap_zero", ob_addr, 32'h0);

    // random traffic
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
           $urandom_range(0, 99) < 3, $urandom, $urandom_range(1, 4));

    // asynchronous reset mid-stream
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 1);
    chk("pre_rst_valid", {31'd0, ob_valid}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("arst_req", {31'd0, imem_req_o}, 32'd0);
    chk("arst_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("arst_instr", instr_o, 32'd0);
    drive_idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    step(1, 1, 0, 0, 1);
    chk("post_rst_addr", ob_addr, RPC);
    chk("post_rst_req", {31'd0, ob_req}, 32'd1);
    for (int i = 0; i < 10; i++) step(1, 1, 0, 0, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
